// File: rtl/channel_check_sequencer.sv
// channel_check_sequencer: runs generate/analyze rounds on a 16-channel analyzer and
// streams a 6-byte per-channel verdict frame over a valid/ready byte link.
module channel_check_sequencer #(
  parameter int GEN_CYCLES = 4096,
  parameter int ANA_CYCLES = 512,
  parameter int PASSES     = 8,
  parameter int FAIL_TOL   = 0
) (
  input  logic        CLK_100MHz,
  input  logic        RST_N,
  input  logic        start,
  output logic        enable_generate,
  input  logic [15:0] status_wire,
  input  logic [15:0] status_gen,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        all_ok
);
  typedef enum logic [2:0] {IDLE, GEN, ANA, SAMPLE, REPORT, DONE} state_t;
  localparam logic [15:0] GEN_LAST   = 16'(GEN_CYCLES - 1);
  localparam logic [15:0] ANA_LAST   = 16'(ANA_CYCLES - 1);
  localparam logic [7:0]  ROUND_LAST = 8'(PASSES - 1);
  localparam logic [7:0]  TOL        = 8'(FAIL_TOL);
  state_t      state_q;
  logic [15:0] phase_q;
  logic [7:0]  round_q;
  logic [2:0]  byte_q;
  logic [7:0]  wfail_q [16];
  logic [7:0]  gfail_q [16];
  logic [7:0]  wfail_d [16];
  logic [7:0]  gfail_d [16];
  logic [15:0] wire_ok, gen_ok;
  logic [7:0]  frame [8];
  logic        en_q, tx_valid_q, busy_q, done_q, all_ok_q;
  logic [7:0]  tx_data_q;
  assign enable_generate = en_q;
  assign tx_data         = tx_data_q;
  assign tx_valid        = tx_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign all_ok          = all_ok_q;
  // saturating per-channel fail counts for the sample about to be taken
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      wfail_d[i] = wfail_q[i] + 8'(!status_wire[i] && wfail_q[i] != 8'hFF);
      gfail_d[i] = gfail_q[i] + 8'(!status_gen[i] && gfail_q[i] != 8'hFF);
      wire_ok[i] = wfail_q[i] <= TOL;
      gen_ok[i]  = gfail_q[i] <= TOL;
    end
  end
  always_comb begin
    frame[0] = 8'hA5;
    frame[1] = wire_ok[15:8];
    frame[2] = wire_ok[7:0];
    frame[3] = gen_ok[15:8];
    frame[4] = gen_ok[7:0];
    frame[5] = 8'hA5 ^ wire_ok[15:8] ^ wire_ok[7:0] ^ gen_ok[15:8] ^ gen_ok[7:0];
    frame[6] = 8'h00;
    frame[7] = 8'h00;
  end
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      round_q    <= '0;
      byte_q     <= '0;
      wfail_q    <= '{default: '0};
      gfail_q    <= '{default: '0};
      en_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      all_ok_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q  <= GEN;
          phase_q  <= '0;
          round_q  <= '0;
          wfail_q  <= '{default: '0};
          gfail_q  <= '{default: '0};
          en_q     <= 1'b1;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
          all_ok_q <= 1'b0;
        end
        GEN: if (phase_q == GEN_LAST) begin
          state_q <= ANA;
          phase_q <= '0;
          en_q    <= 1'b0;
          wfail_q <= wfail_d;
        end else begin
          phase_q <= phase_q + 16'd1;
        end
        ANA: if (phase_q == ANA_LAST) begin
          state_q <= SAMPLE;
          phase_q <= '0;
          gfail_q <= gfail_d;
        end else begin
          phase_q <= phase_q + 16'd1;
        end
        SAMPLE: if (round_q == ROUND_LAST) begin
          state_q    <= REPORT;
          byte_q     <= '0;
          tx_valid_q <= 1'b1;
          tx_data_q  <= frame[0];
        end else begin
          state_q <= GEN;
          round_q <= round_q + 8'd1;
          en_q    <= 1'b1;
        end
        REPORT: if (tx_ready) begin
          if (byte_q == 3'd5) begin
            state_q    <= DONE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            all_ok_q   <= &wire_ok & &gen_ok;
          end else begin
            byte_q    <= byte_q + 3'd1;
            tx_data_q <= frame[byte_q + 3'd1];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
